// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline (PC, IF/ID, ID/EX,
//   EX/MEM, MEM/WB). It detects load-use hazards, taken branches/jumps and
//   data-memory wait, and drives the per-stage enable/flush lines. The pipe
//   registers sample on the falling edge, while this block updates on the
//   rising edge, so its Mealy outputs settle half a cycle before they are used.
//
// Ports
//   clk, reset                    clock (rising edge), async active-low reset
//   id_rs, id_rt, id_uses_rt      source operands of the instruction in ID
//   ex_mem_read, ex_rt            load in EX and its destination register
//   branch_taken, jump            control transfer resolved/decoded in ID
//   mem_busy                      data memory not ready this cycle
//   pc_en, *_en, *_flush          stage enables and NOP/bubble inserts
//   state                         0=RUN 1=LOAD_STALL 2=MEM_WAIT
//   stall_count                   saturating count of cycles with pc_en==0
//   watchdog_err                  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic             watchdog_err
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MEMW = 2'd2;

  localparam int WC_W = (MAX_MEM_WAIT < 1) ? 1 : $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_MEM_WAIT);

  logic [1:0]       r_state, w_nxt;
  logic [WC_W-1:0]  r_wait, w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_wd;
  logic             w_load_use;
  logic             w_pc, w_ifid, w_ifid_fl, w_idex, w_idex_fl, w_exmem, w_memwb;

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Unused code 3 falls through every state test below and acts as RUN.
  always_comb begin
    w_pc       = 1'b1;
    w_ifid     = 1'b1;
    w_ifid_fl  = 1'b0;
    w_idex     = 1'b1;
    w_idex_fl  = 1'b0;
    w_exmem    = 1'b1;
    w_memwb    = 1'b1;
    w_nxt      = S_RUN;
    w_wait_nxt = '0;
    if (mem_busy) begin
      w_pc    = 1'b0;
      w_ifid  = 1'b0;
      w_idex  = 1'b0;
      w_exmem = 1'b0;
      w_memwb = 1'b0;
      w_nxt   = S_MEMW;
      if (r_state == S_MEMW)
        w_wait_nxt = (r_wait >= WC_MAX) ? r_wait : r_wait + WC_W'(1);
      else
        w_wait_nxt = WC_W'(1);
    end else if (w_load_use && (r_state != S_LOAD)) begin
      // One bubble per load: the stalled instruction re-presents the same
      // hazard next cycle, which LOAD_STALL deliberately ignores.
      w_pc      = 1'b0;
      w_ifid    = 1'b0;
      w_idex_fl = 1'b1;
      w_nxt     = S_LOAD;
    end else if (branch_taken || jump) begin
      w_ifid_fl = 1'b1;
    end
  end

  // Reset forces every enable and flush low regardless of inputs.
  assign pc_en        = reset & w_pc;
  assign ifid_en      = reset & w_ifid;
  assign ifid_flush   = reset & w_ifid_fl;
  assign idex_en      = reset & w_idex;
  assign idex_flush   = reset & w_idex_fl;
  assign exmem_en     = reset & w_exmem;
  assign memwb_en     = reset & w_memwb;
  assign state        = r_state;
  assign stall_count  = r_stall_cnt;
  assign watchdog_err = r_wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_wait      <= '0;
      r_stall_cnt <= '0;
      r_wd        <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wait  <= w_wait_nxt;
      if (!w_pc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (mem_busy && (w_wait_nxt >= WC_MAX))
        r_wd <= 1'b1;
    end
  end

endmodule
